// File: rtl/fetch_stage_if.sv
//------------------------------------------------------------------------------
// fetch_stage_if
// Control, instruction-memory and IF/ID signals of the fetch stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignedD;

    // Hazard unit, EX redirect and instruction memory side
    modport master (
        output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignedD
    );

    modport slave (
        input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignedD
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage
// RV32I instruction fetch: PC register plus IF/ID pipeline register.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    fetch_stage_if.slave   bus
);

    // Only the word address is stored, so PCF[1:0] is structurally zero
    logic [29:0] r_pc_word;
    logic        r_misalign;

    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic        r_misaligned_d;

    logic [31:0] w_pcf;
    logic [31:0] w_pcf_plus4;

    assign w_pcf       = {r_pc_word, 2'b00};
    assign w_pcf_plus4 = w_pcf + 32'd4;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc_word  <= RESET_PC[31:2];
            r_misalign <= 1'b0;
        end else if (bus.PCSrcE) begin
            r_pc_word  <= bus.PCTargetE[31:2];
            r_misalign <= |bus.PCTargetE[1:0];
        end else if (!bus.StallF) begin
            r_pc_word  <= r_pc_word + 30'd1;
            r_misalign <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || bus.FlushD) begin
            r_instr_d      <= NOP_INSTR;
            r_pc_d         <= 32'd0;
            r_pc_plus4_d   <= 32'd0;
            r_valid_d      <= 1'b0;
            r_misaligned_d <= 1'b0;
        end else if (!bus.StallD) begin
            r_instr_d      <= bus.InstrF;
            r_pc_d         <= w_pcf;
            r_pc_plus4_d   <= w_pcf_plus4;
            r_valid_d      <= 1'b1;
            r_misaligned_d <= r_misalign;
        end
    end

    assign bus.PCF         = w_pcf;
    assign bus.InstrD      = r_instr_d;
    assign bus.PCD         = r_pc_d;
    assign bus.PCPlus4D    = r_pc_plus4_d;
    assign bus.ValidD      = r_valid_d;
    assign bus.MisalignedD = r_misaligned_d;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage: directed scenarios then random control.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pcp4;
        logic        valid;
        logic        mis;
    } exp_t;

    logic clk;
    logic reset_n;
    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP_INSTR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: a few real words, a hash elsewhere
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem = 32'h0050_0093;
            32'h0000_0004: imem = 32'h00A0_0113;
            32'h0000_0008: imem = 32'h0020_81B3;
            32'h0000_000C: imem = 32'h0000_0013;
            default:       imem = (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
        endcase
    endfunction

    assign bus.InstrF = imem(bus.PCF);

    // Reference model state (architectural view)
    logic [31:0] m_pc;
    logic        m_flag;
    exp_t        m_ifid;
    exp_t        q[$];
    int          n_total;
    int          n_pass;
    bit          stim_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, req, $time);
    endtask

    // One clock of stimulus; expected post-edge state is queued
    task automatic step(input bit rn, input bit sf, input bit sd, input bit fd,
                        input bit ps, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        reset_n       = rn;
        bus.StallF    = sf;
        bus.StallD    = sd;
        bus.FlushD    = fd;
        bus.PCSrcE    = ps;
        bus.PCTargetE = tgt;
        if (!rn) begin
            m_pc   = C_RESET_PC;
            m_flag = 1'b0;
            m_ifid = '{pcf: 32'd0, instr: C_NOP_INSTR, pcd: 32'd0, pcp4: 32'd0, valid: 1'b0, mis: 1'b0};
        end else begin
            if (fd)
                m_ifid = '{pcf: 32'd0, instr: C_NOP_INSTR, pcd: 32'd0, pcp4: 32'd0, valid: 1'b0, mis: 1'b0};
            else if (!sd)
                m_ifid = '{pcf: 32'd0, instr: imem(m_pc), pcd: m_pc, pcp4: m_pc + 32'd4, valid: 1'b1, mis: m_flag};
            if (ps) begin
                m_pc   = tgt & 32'hFFFF_FFFC;
                m_flag = (tgt % 4) != 0;
            end else if (!sf) begin
                m_pc   = m_pc + 32'd4;
                m_flag = 1'b0;
            end
        end
        e     = m_ifid;
        e.pcf = m_pc;
        q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: compares every cycle's registered outputs against the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("PCF",         bus.PCF,                 e.pcf);
                chk("InstrD",      bus.InstrD,              e.instr);
                chk("PCD",         bus.PCD,                 e.pcd);
                chk("PCPlus4D",    bus.PCPlus4D,            e.pcp4);
                chk("ValidD",      {31'd0, bus.ValidD},     {31'd0, e.valid});
                chk("MisalignedD", {31'd0, bus.MisalignedD}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [31:0] t;
        n_total = 0;
        n_pass  = 0;
        stim_done = 1'b0;
        reset_n = 1'b0;
        bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0;
        bus.PCSrcE = 1'b0; bus.PCTargetE = 32'd0;
        m_pc = C_RESET_PC; m_flag = 1'b0; m_ifid = '0;

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run(2);                                                   // PCF reaches 8
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        run(2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040);        // redirect beats stall
        run(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0046);        // misaligned target
        run(3);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);                // flush beats stall
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(3);                                                   // wrap to 0
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0123);        // reset beats redirect
        run(1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);                // StallF without StallD
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0203);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);                // flag held over stall
        run(2);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            t = (r == 0) ? {28'hFFF_FFFF, 4'($urandom)} : $urandom;
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 t);
        end

        @(negedge clk);
        @(negedge clk);
        chk("drain", q.size(), 32'd0);
        stim_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
